// File: rtl/legv8_mem_pkg.sv
// Shared types and constants for the LEGv8 data-memory port arbiter.
// Holds the arbiter state encoding, default bus widths and latency counter width.
package legv8_mem_pkg;

   localparam int ADDR_W_DEF = 64;
   localparam int DATA_W_DEF = 64;
   localparam int LAT_W      = 4;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      ACC1 = 2'd1,
      ACC2 = 2'd2
   } arb_state_t;

endpackage

// File: rtl/dmem_req_latch.sv
// Per-slot capture register for one issue slot's access (we/addr/wdata)
// plus that slot's registered load result.
module dmem_req_latch
   import legv8_mem_pkg::*;
#(
   parameter int ADDR_W = ADDR_W_DEF,
   parameter int DATA_W = DATA_W_DEF
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              capture,
   input  logic              we,
   input  logic [ADDR_W-1:0] addr,
   input  logic [DATA_W-1:0] wdata,
   input  logic              load_en,
   input  logic [DATA_W-1:0] mem_data_in,
   output logic              cap_we,
   output logic [ADDR_W-1:0] cap_addr,
   output logic [DATA_W-1:0] cap_wdata,
   output logic [DATA_W-1:0] rdata
);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cap_we    <= 1'b0;
         cap_addr  <= '0;
         cap_wdata <= '0;
         rdata     <= '0;
      end else begin
         if (capture) begin
            cap_we    <= we;
            cap_addr  <= addr;
            cap_wdata <= wdata;
         end
         // rdata holds its value until the next load on this slot completes
         if (load_en) rdata <= mem_data_in;
      end
   end

endmodule

// File: rtl/dmem_port_arbiter.sv
// Serializes the two issue slots' loads/stores onto the single Data_Memory port,
// slot 1 before slot 2, and stalls the core while any access is outstanding.
module dmem_port_arbiter
   import legv8_mem_pkg::*;
#(
   parameter int ADDR_W  = ADDR_W_DEF,
   parameter int DATA_W  = DATA_W_DEF,
   parameter int MEM_LAT = 1
) (
   input  logic              CLOCK,
   input  logic              RESET,
   input  logic              req1,
   input  logic              req2,
   input  logic              we1,
   input  logic              we2,
   input  logic [ADDR_W-1:0] addr1,
   input  logic [ADDR_W-1:0] addr2,
   input  logic [DATA_W-1:0] wdata1,
   input  logic [DATA_W-1:0] wdata2,
   output logic              done1,
   output logic              done2,
   output logic [DATA_W-1:0] rdata1,
   output logic [DATA_W-1:0] rdata2,
   output logic              stall,
   output logic [ADDR_W-1:0] mem_address,
   output logic [DATA_W-1:0] mem_data_out,
   output logic              mem_memwrite,
   output logic              mem_memread,
   input  logic [DATA_W-1:0] mem_data_in,
   output arb_state_t        dbg_state
);

   if (MEM_LAT < 1 || MEM_LAT > 15) begin : g_bad_lat
      $fatal(1, "dmem_port_arbiter: MEM_LAT must be within 1..15");
   end

   localparam logic [LAT_W-1:0] LAST_CNT = LAT_W'(MEM_LAT - 1);

   arb_state_t        state, state_nxt;
   logic [LAT_W-1:0]  cnt, cnt_nxt;
   logic              pending2, pending2_nxt;
   logic              done1_nxt, done2_nxt;
   logic              cap1, cap2, ld1, ld2;
   logic              last;
   logic              elig1, elig2;
   logic              c1_we, c2_we;
   logic [ADDR_W-1:0] c1_addr, c2_addr;
   logic [DATA_W-1:0] c1_wdata, c2_wdata;

   // Handshake: reqX is a level held until doneX; doneX is a one-cycle registered
   // pulse, and a reqX seen while its own doneX is high is never accepted.
   assign elig1 = req1 & ~done1;
   assign elig2 = req2 & ~done2;
   assign last  = (cnt == LAST_CNT);
   assign stall = (state != IDLE) | elig1 | elig2;
   assign dbg_state = state;

   always_ff @(posedge CLOCK or negedge RESET) begin
      if (!RESET) begin
         state    <= IDLE;
         cnt      <= '0;
         pending2 <= 1'b0;
         done1    <= 1'b0;
         done2    <= 1'b0;
      end else begin
         state    <= state_nxt;
         cnt      <= cnt_nxt;
         pending2 <= pending2_nxt;
         done1    <= done1_nxt;
         done2    <= done2_nxt;
      end
   end

   always_comb begin
      state_nxt    = state;
      cnt_nxt      = cnt;
      pending2_nxt = pending2;
      done1_nxt    = 1'b0;
      done2_nxt    = 1'b0;
      cap1         = 1'b0;
      cap2         = 1'b0;
      ld1          = 1'b0;
      ld2          = 1'b0;
      unique case (state)
         IDLE: begin
            cnt_nxt = '0;
            if (elig1) begin
               cap1      = 1'b1;
               state_nxt = ACC1;
               if (elig2) begin
                  cap2         = 1'b1;
                  pending2_nxt = 1'b1;
               end
            end else if (elig2) begin
               cap2      = 1'b1;
               state_nxt = ACC2;
            end
         end
         ACC1: begin
            if (last) begin
               cnt_nxt   = '0;
               done1_nxt = 1'b1;
               ld1       = ~c1_we;
               if (pending2) begin
                  state_nxt    = ACC2;
                  pending2_nxt = 1'b0;
               end else begin
                  state_nxt = IDLE;
               end
            end else begin
               cnt_nxt = cnt + LAT_W'(1);
            end
         end
         ACC2: begin
            if (last) begin
               cnt_nxt   = '0;
               done2_nxt = 1'b1;
               ld2       = ~c2_we;
               state_nxt = IDLE;
            end else begin
               cnt_nxt = cnt + LAT_W'(1);
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   // Port is driven purely from state, so an async reset drops every strobe at once
   always_comb begin
      mem_address  = '0;
      mem_data_out = '0;
      mem_memwrite = 1'b0;
      mem_memread  = 1'b0;
      unique case (state)
         ACC1: begin
            mem_address  = c1_addr;
            mem_data_out = c1_wdata;
            mem_memwrite = c1_we;
            mem_memread  = ~c1_we;
         end
         ACC2: begin
            mem_address  = c2_addr;
            mem_data_out = c2_wdata;
            mem_memwrite = c2_we;
            mem_memread  = ~c2_we;
         end
         default: ;
      endcase
   end

   dmem_req_latch #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) u_slot1 (
      .clk         (CLOCK),
      .rst_n       (RESET),
      .capture     (cap1),
      .we          (we1),
      .addr        (addr1),
      .wdata       (wdata1),
      .load_en     (ld1),
      .mem_data_in (mem_data_in),
      .cap_we      (c1_we),
      .cap_addr    (c1_addr),
      .cap_wdata   (c1_wdata),
      .rdata       (rdata1)
   );

   dmem_req_latch #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) u_slot2 (
      .clk         (CLOCK),
      .rst_n       (RESET),
      .capture     (cap2),
      .we          (we2),
      .addr        (addr2),
      .wdata       (wdata2),
      .load_en     (ld2),
      .mem_data_in (mem_data_in),
      .cap_we      (c2_we),
      .cap_addr    (c2_addr),
      .cap_wdata   (c2_wdata),
      .rdata       (rdata2)
   );

endmodule

// File: tb/tb_dmem_port_arbiter.sv
// Bench for dmem_port_arbiter: directed literal scenarios plus randomized traffic
// checked every cycle against a transaction-level schedule model.
module tb_dmem_port_arbiter;
   import legv8_mem_pkg::*;

   localparam int LAT = 2;

   logic        CLOCK, RESET;
   logic        req1, req2, we1, we2;
   logic [63:0] addr1, addr2, wdata1, wdata2;
   logic        done1, done2, stall, mem_memwrite, mem_memread;
   logic [63:0] rdata1, rdata2, mem_address, mem_data_out, mem_data_in;
   arb_state_t  dbg_state;

   int total = 0;
   int bad   = 0;

   logic [63:0] ram [0:15];

   dmem_port_arbiter #(.ADDR_W(64), .DATA_W(64), .MEM_LAT(LAT)) dut (
      .CLOCK(CLOCK), .RESET(RESET),
      .req1(req1), .req2(req2), .we1(we1), .we2(we2),
      .addr1(addr1), .addr2(addr2), .wdata1(wdata1), .wdata2(wdata2),
      .done1(done1), .done2(done2), .rdata1(rdata1), .rdata2(rdata2),
      .stall(stall), .mem_address(mem_address), .mem_data_out(mem_data_out),
      .mem_memwrite(mem_memwrite), .mem_memread(mem_memread),
      .mem_data_in(mem_data_in), .dbg_state(dbg_state)
   );

   // clock / RAM
   initial begin
      CLOCK = 1'b0;
      forever #5 CLOCK = ~CLOCK;
   end

   assign mem_data_in = ram[mem_address[3:0]];

   always @(posedge CLOCK) begin
      if (mem_memwrite) ram[mem_address[3:0]] <= mem_data_out;
   end

   initial begin
      #400000;
      $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
      $fatal(1, "watchdog");
   end

   // behavioural model: each accepted access owns the port for LAT cycles in order
   typedef struct {
      int          start;
      bit          we;
      logic [63:0] addr;
      logic [63:0] wdata;
   } acc_t;

   acc_t        acc_q[$];
   int          n       = 0;
   int          idle_at = 0;
   int          done_cyc [2];
   bit          p_we     [2];
   logic [63:0] p_addr   [2];
   logic [63:0] p_wdata  [2];
   bit          exp_done [2];
   logic [63:0] exp_rdata[2];
   logic [63:0] exp_mem  [0:15];

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h at t=%0t", name, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      acc_q.delete();
      idle_at = 0;
      for (int s = 0; s < 2; s++) begin
         done_cyc[s]  = -1;
         exp_done[s]  = 1'b0;
         exp_rdata[s] = '0;
      end
   endtask

   task automatic schedule(input int s, input int st, input bit w, input logic [63:0] a,
                           input logic [63:0] d);
      acc_q.push_back('{start: st, we: w, addr: a, wdata: d});
      done_cyc[s] = st + LAT;
      p_we[s]     = w;
      p_addr[s]   = a;
      p_wdata[s]  = d;
   endtask

   task automatic model_step();
      logic [63:0] e_addr, e_data;
      bit          e_wr, e_rd, e_stall, e1, e2;
      int          st;
      for (int s = 0; s < 2; s++) begin
         exp_done[s] = (done_cyc[s] == n);
         if (exp_done[s]) begin
            if (p_we[s]) exp_mem[p_addr[s][3:0]] = p_wdata[s];
            else         exp_rdata[s] = exp_mem[p_addr[s][3:0]];
            done_cyc[s] = -1;
         end
      end
      e_addr = '0; e_data = '0; e_wr = 1'b0; e_rd = 1'b0;
      while (acc_q.size() > 0 && acc_q[0].start + LAT <= n) void'(acc_q.pop_front());
      if (acc_q.size() > 0 && acc_q[0].start <= n) begin
         e_addr = acc_q[0].addr;
         e_data = acc_q[0].wdata;
         e_wr   = acc_q[0].we;
         e_rd   = !acc_q[0].we;
      end
      e1 = req1 && !exp_done[0];
      e2 = req2 && !exp_done[1];
      e_stall = (n < idle_at) || e1 || e2;
      chk("m_done1", 64'(done1), 64'(exp_done[0]));
      chk("m_done2", 64'(done2), 64'(exp_done[1]));
      chk("m_rdata1", rdata1, exp_rdata[0]);
      chk("m_rdata2", rdata2, exp_rdata[1]);
      chk("m_stall", 64'(stall), 64'(e_stall));
      chk("m_addr", mem_address, e_addr);
      chk("m_wdata", mem_data_out, e_data);
      chk("m_memwrite", 64'(mem_memwrite), 64'(e_wr));
      chk("m_memread", 64'(mem_memread), 64'(e_rd));
      if (n >= idle_at) begin
         st = n + 1;
         if (e1) begin schedule(0, st, we1, addr1, wdata1); st += LAT; end
         if (e2) begin schedule(1, st, we2, addr2, wdata2); st += LAT; end
         if (e1 || e2) idle_at = st;
      end
      n++;
   endtask

   // driver tasks: drive after the rising edge, sample/check on the falling edge
   task automatic tick();
      @(posedge CLOCK);
      #1;
   endtask

   task automatic samp();
      @(negedge CLOCK);
      if (RESET) model_step();
      else       model_reset();
      #1;
   endtask

   task automatic idle_cycles(input int k);
      repeat (k) begin tick(); samp(); end
   endtask

   // slot driver state: 0 idle, 1 waiting for done, 2 holding req through done cycle
   task automatic drive_slot(input logic dn, input bit allow_new, inout int st,
                             inout logic rq, inout logic w, inout logic [63:0] a,
                             inout logic [63:0] d);
      case (st)
         1: if (dn) begin
               if ($urandom_range(0, 3) == 0) st = 2;
               else begin rq = 1'b0; st = 0; end
            end
         2: begin rq = 1'b0; st = 0; end
         default:
            if (allow_new && $urandom_range(0, 2) == 0) begin
               rq = 1'b1;
               w  = 1'($urandom_range(0, 1));
               a  = 64'($urandom_range(0, 15));
               d  = {$urandom, $urandom};
               st = 1;
            end
      endcase
   endtask

   bit d_wr [6] = '{0, 1, 1, 0, 0, 0};
   bit d_rd [6] = '{0, 0, 0, 1, 1, 0};
   bit d_d1 [6] = '{0, 0, 0, 1, 0, 0};
   bit d_d2 [6] = '{0, 0, 0, 0, 0, 1};
   bit d_st [6] = '{1, 1, 1, 1, 1, 0};
   bit s_wr [4] = '{0, 1, 1, 0};
   bit s_d2 [4] = '{0, 0, 0, 1};
   bit s_st [4] = '{1, 1, 1, 0};
   bit h_rd [5] = '{0, 1, 1, 0, 0};
   bit h_d1 [5] = '{0, 0, 0, 1, 0};

   int  st1, st2;
   bit  drained;

   initial begin
      RESET = 1'b0;
      req1 = 1'b0; req2 = 1'b0; we1 = 1'b0; we2 = 1'b0;
      addr1 = '0; addr2 = '0; wdata1 = '0; wdata2 = '0;
      for (int i = 0; i < 16; i++) begin ram[i] = '0; exp_mem[i] = '0; end
      model_reset();
      idle_cycles(3);
      chk("rst_done1", 64'(done1), 64'd0);
      chk("rst_rdata1", rdata1, 64'd0);
      chk("rst_stall", 64'(stall), 64'd0);
      chk("rst_memwrite", 64'(mem_memwrite), 64'd0);
      chk("rst_state", 64'(dbg_state), 64'(IDLE));
      tick(); RESET = 1'b1; samp();
      idle_cycles(2);

      // dual request: slot 1 stores 0x55 to 2, slot 2 loads 2
      for (int c = 0; c < 6; c++) begin
         tick();
         if (done1) req1 = 1'b0;
         if (done2) req2 = 1'b0;
         if (c == 0) begin
            req1 = 1'b1; we1 = 1'b1; addr1 = 64'd2; wdata1 = 64'h55;
            req2 = 1'b1; we2 = 1'b0; addr2 = 64'd2; wdata2 = 64'h0;
         end
         samp();
         chk("dual_memwrite", 64'(mem_memwrite), 64'(d_wr[c]));
         chk("dual_memread", 64'(mem_memread), 64'(d_rd[c]));
         chk("dual_done1", 64'(done1), 64'(d_d1[c]));
         chk("dual_done2", 64'(done2), 64'(d_d2[c]));
         chk("dual_stall", 64'(stall), 64'(d_st[c]));
      end
      chk("dual_rdata2", rdata2, 64'h55);
      idle_cycles(2);

      // slot 2 alone: store 0x77 to 8
      for (int c = 0; c < 4; c++) begin
         tick();
         if (done2) req2 = 1'b0;
         if (c == 0) begin req2 = 1'b1; we2 = 1'b1; addr2 = 64'd8; wdata2 = 64'h77; end
         samp();
         if (c == 1) chk("s2_state", 64'(dbg_state), 64'(ACC2));
         chk("s2_memwrite", 64'(mem_memwrite), 64'(s_wr[c]));
         chk("s2_done2", 64'(done2), 64'(s_d2[c]));
         chk("s2_done1", 64'(done1), 64'd0);
         chk("s2_stall", 64'(stall), 64'(s_st[c]));
      end
      chk("s2_ram8", ram[8], 64'h77);
      idle_cycles(2);

      // load with req1 held through its done cycle
      for (int c = 0; c < 5; c++) begin
         tick();
         if (c == 0) begin req1 = 1'b1; we1 = 1'b0; addr1 = 64'd2; wdata1 = 64'h0; end
         if (c == 4) req1 = 1'b0;
         samp();
         chk("hold_memread", 64'(mem_memread), 64'(h_rd[c]));
         chk("hold_done1", 64'(done1), 64'(h_d1[c]));
         if (c >= 3) chk("hold_stall", 64'(stall), 64'd0);
      end
      chk("hold_rdata1", rdata1, 64'h55);
      chk("hold_state", 64'(dbg_state), 64'(IDLE));
      idle_cycles(2);

      // reset asserted in the middle of an ACC1 store
      tick();
      req1 = 1'b1; we1 = 1'b1; addr1 = 64'd5; wdata1 = 64'h99;
      samp();
      tick();
      chk("mid_memwrite_pre", 64'(mem_memwrite), 64'd1);
      RESET = 1'b0;
      req1  = 1'b0;
      #1;
      chk("mid_memwrite", 64'(mem_memwrite), 64'd0);
      chk("mid_address", mem_address, 64'd0);
      chk("mid_stall", 64'(stall), 64'd0);
      chk("mid_rdata1", rdata1, 64'd0);
      chk("mid_rdata2", rdata2, 64'd0);
      chk("mid_state", 64'(dbg_state), 64'(IDLE));
      samp();
      idle_cycles(2);
      tick(); RESET = 1'b1; samp();
      idle_cycles(2);
      chk("mid_ram5", ram[5], 64'd0);
      chk("mid_state_after", 64'(dbg_state), 64'(IDLE));

      // randomized traffic from both slots
      st1 = 0; st2 = 0;
      for (int i = 0; i < 1500; i++) begin
         tick();
         drive_slot(done1, 1'b1, st1, req1, we1, addr1, wdata1);
         drive_slot(done2, 1'b1, st2, req2, we2, addr2, wdata2);
         samp();
      end
      drained = 1'b0;
      for (int i = 0; i < 100 && !drained; i++) begin
         tick();
         drive_slot(done1, 1'b0, st1, req1, we1, addr1, wdata1);
         drive_slot(done2, 1'b0, st2, req2, we2, addr2, wdata2);
         samp();
         if (st1 == 0 && st2 == 0 && !stall) drained = 1'b1;
      end
      chk("drain_timeout", 64'(drained), 64'd1);
      idle_cycles(2);
      for (int i = 0; i < 16; i++) chk("final_ram", ram[i], exp_mem[i]);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/dmem_port_arbiter.md
# dmem_port_arbiter

Arbitrates the two issue slots of the dual-issue LEGv8 core onto the single-ported Data_Memory. Each slot's load/store is serialized onto one memory port in program order: slot 1 is always older than slot 2. A stall signal freezes the core while any accepted access is outstanding. The block sits between the core's two memory interfaces and the RAM instance.

## Interface
Parameters:
- ADDR_W, 64, memory address width
- DATA_W, 64, memory data width
- MEM_LAT, 1, cycles the memory port is held per access; legal range 1..15

Ports:
- CLOCK  in  1  system clock, rising edge
- RESET  in  1  asynchronous, active-low reset
- req1 / req2  in  1  slot access request; level, held until the matching done
- we1 / we2  in  1  1 = store, 0 = load; sampled with req
- addr1 / addr2  in  ADDR_W  access address
- wdata1 / wdata2  in  DATA_W  store data
- done1 / done2  out  1  one-cycle completion pulse, registered
- rdata1 / rdata2  out  DATA_W  load result, registered, held until the next load on that slot
- stall  out  1  core freeze request
- mem_address  out  ADDR_W  to RAM
- mem_data_out  out  DATA_W  store data to RAM
- mem_memwrite  out  1  RAM write strobe
- mem_memread  out  1  RAM read strobe
- mem_data_in  in  DATA_W  RAM read data, combinational from mem_address

## Operation
- FSM states: IDLE, ACC1, ACC2. Reset state is IDLE.
- IDLE acceptance:
  - reqX is eligible only when doneX=0 in the same cycle. A requester drops req in its done cycle and is never re-accepted.
  - Eligible req1: capture we1/addr1/wdata1 and go to ACC1. If req2 is also eligible, capture slot 2 too and set pending2.
  - Eligible req2 only: capture slot 2 and go to ACC2.
- ACCx:
  - Drive mem_address/mem_data_out from the captured slot.
  - Assert mem_memread (load) or mem_memwrite (store) on every cycle of the state.
  - A 4-bit counter runs 0..MEM_LAT-1.
- Final ACCx cycle (counter = MEM_LAT-1):
  - For a load, rdataX <= mem_data_in.
  - doneX <= 1.
  - Counter clears.
  - Next state: ACC1 with pending2 set goes to ACC2 and clears pending2. Otherwise go to IDLE.
- Requests are not accepted outside IDLE. A req arriving during ACCx waits for IDLE.
- Idle memory port: mem_address=0, mem_data_out=0, mem_memread=0, mem_memwrite=0.
- stall = (state≠IDLE) | (req1 & ~done1) | (req2 & ~done2).
- Same address in both slots: serialization guarantees slot 2 observes slot 1's store. No forwarding path exists.
- Both slots storing to the same address: slot 2's value remains in memory.
- Reset asserted mid-access:
  - Immediately (asynchronously) force IDLE.
  - Counter, pending2, done1/done2 and rdata1/rdata2 go to 0.
  - All mem_* outputs go to 0. The aborted access is lost, and mem_memwrite never glitches high.

## Timing
- Reset values: every output 0.
- With MEM_LAT=L, a single request accepted in cycle 0 gives:
  - ACCx in cycles 1..L
  - doneX=1 and rdataX valid in cycle L+1
  - stall high in cycles 0..L and low in cycle L+1, provided no other request is pending
- Dual request in cycle 0:
  - ACC1 in cycles 1..L, with done1 in cycle L+1
  - ACC2 in cycles L+1..2L, with done2 in cycle 2L+1
  - stall low in cycle 2L+1
- Back-to-back: a new request presented in the done cycle is ignored for that slot. A request from the other slot in that cycle is accepted if the FSM is in IDLE.
- The counter never wraps. The MEM_LAT range is checked at elaboration, and a value outside 1..15 is a fatal error.

## Structure
- Shared package legv8_mem_pkg holds:
  - the state enum (IDLE, ACC1, ACC2)
  - ADDR_W/DATA_W defaults
  - the LAT_W=4 constant
- One natural sub-module, dmem_req_latch, instantiated once per slot. It holds the capture register for we/addr/wdata plus the rdata register.
- The FSM, counter and output multiplexing live in the top.

## Test plan
- Single load, MEM_LAT=1: RAM[0x10]=0xAB, req1 load addr 0x10 in cycle 0 -> mem_memread high in cycle 1, done1 and rdata1=0xAB in cycle 2, stall 1,1,0.
- Dual request, MEM_LAT=2: slot 1 stores 0x55 to 0x20, slot 2 loads 0x20, both in cycle 0 -> memwrite in cycles 1–2, done1 in cycle 3, memread in cycles 3–4, done2 with rdata2=0x55 in cycle 5.
- Slot 2 only: req2 store 0x77 to 0x08 -> the FSM goes to ACC2 directly, done2 in cycle 2, done1 stays 0, RAM[0x08]=0x77.
- Late request: req2 raised in cycle 1 during ACC1 -> accepted at the cycle 2 IDLE, done2 in cycle 4 (MEM_LAT=1).
- Reset mid-op: RESET low during the ACC1 store cycle -> all outputs 0 within the same cycle, no write committed, FSM in IDLE after release.
- Done-cycle hold: req1 kept high during its done cycle -> not re-accepted and stall=0 that cycle.
